// File: rtl/registrador_pipeline.sv
// registrador_pipeline: elastic register pipeline with valid/ready flow control.
// LARGURA-bit words cross ESTAGIOS register stages. A valid word moves into any
// empty downstream stage, so bubbles collapse instead of travelling to the output.
// All state changes on the falling edge of clk. reset is synchronous, active-low.
// limpar is a synchronous flush that drops every word and keeps the data registers.
// ocupacao counts the stages that hold a valid word.
// Optional macro REGISTRADOR_PIPELINE_PARIDADE_EN adds a stored even-parity bit per
// stage and the erro_paridade output.

module registrador_pipeline #(
    parameter int LARGURA  = 8,
    parameter int ESTAGIOS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [LARGURA-1:0]                entrada_dado,
    input  logic                              entrada_valida,
    output logic                              entrada_pronta,
    output logic [LARGURA-1:0]                saida_registrada,
    output logic                              saida_valida,
    input  logic                              saida_pronta,
    input  logic                              limpar,
    output logic [$clog2(ESTAGIOS+1)-1:0]     ocupacao
`ifdef REGISTRADOR_PIPELINE_PARIDADE_EN
    ,
    output logic                              erro_paridade
`endif
);

    localparam int OW = $clog2(ESTAGIOS+1);

    logic [LARGURA-1:0]  dado [ESTAGIOS];
    logic [ESTAGIOS-1:0] valido;
    logic [ESTAGIOS-1:0] avanca;
    logic                entra;
    logic                sai;

    // A stage may load when it is empty or when the stage after it is moving on
    always_comb begin
        avanca = '0;
        avanca[ESTAGIOS-1] = !valido[ESTAGIOS-1] || saida_pronta;
        for (int i = ESTAGIOS - 2; i >= 0; i--) begin
            avanca[i] = !valido[i] || avanca[i+1];
        end
    end

    assign entrada_pronta   = avanca[0] && !limpar;
    assign entra            = entrada_valida && entrada_pronta;
    assign sai              = valido[ESTAGIOS-1] && saida_pronta;
    assign saida_registrada = dado[ESTAGIOS-1];
    assign saida_valida     = valido[ESTAGIOS-1];

    // Stage registers: valid bits always follow upstream, data only loads from a valid source
    always_ff @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ESTAGIOS; i++) begin
                dado[i] <= '0;
            end
            valido <= '0;
        end else if (limpar) begin
            valido <= '0;
        end else begin
            if (avanca[0]) begin
                valido[0] <= entra;
                if (entra) begin
                    dado[0] <= entrada_dado;
                end
            end
            for (int i = 1; i < ESTAGIOS; i++) begin
                if (avanca[i]) begin
                    valido[i] <= valido[i-1];
                    if (valido[i-1]) begin
                        dado[i] <= dado[i-1];
                    end
                end
            end
        end
    end

    // Occupancy counter tracks input and output transfers; a flush empties it
    always_ff @(negedge clk) begin
        if (!reset) begin
            ocupacao <= '0;
        end else if (limpar) begin
            ocupacao <= '0;
        end else begin
            case ({entra, sai})
                2'b10:   ocupacao <= ocupacao + OW'(1);
                2'b01:   ocupacao <= ocupacao - OW'(1);
                default: ocupacao <= ocupacao;
            endcase
        end
    end

`ifdef REGISTRADOR_PIPELINE_PARIDADE_EN
    logic [ESTAGIOS-1:0] paridade;

    // Parity bits travel alongside the data, computed once when the word enters
    always_ff @(negedge clk) begin
        if (!reset) begin
            paridade <= '0;
        end else if (limpar) begin
            paridade <= '0;
        end else begin
            if (avanca[0] && entra) begin
                paridade[0] <= ^entrada_dado;
            end
            for (int i = 1; i < ESTAGIOS; i++) begin
                if (avanca[i] && valido[i-1]) begin
                    paridade[i] <= paridade[i-1];
                end
            end
        end
    end

    assign erro_paridade = saida_valida && ((^saida_registrada) != paridade[ESTAGIOS-1]);
`endif

endmodule

// File: doc/registrador_pipeline.md
Name: registrador_pipeline

Overview:
Parametrised elastic register pipeline for the image coprocessor: LARGURA-bit words pass through ESTAGIOS register stages with valid/ready flow control, bubble collapsing, flush and an occupancy count. It is the successor to the single-bit falling-edge register and is placed between pixel-producing and pixel-consuming units where backpressure must be absorbed. All state updates on the falling edge of clk.

Parameters:
LARGURA, 8, data word width in bits (>=1)
ESTAGIOS, 4, number of register stages (>=1)

Ports:
clk  input  1  clock; all registers update on falling edge
reset  input  1  synchronous reset, active-low (0 = reset), sampled on falling edge of clk
entrada_dado  input  LARGURA  input word
entrada_valida  input  1  entrada_dado holds a valid word
entrada_pronta  output  1  pipeline accepts a word on this edge
saida_registrada  output  LARGURA  word held in last stage
saida_valida  output  1  last stage holds a valid word
saida_pronta  input  1  consumer accepts saida_registrada on this edge
limpar  input  1  synchronous flush, active-high
ocupacao  output  $clog2(ESTAGIOS+1)  number of valid stages

Behaviour:
- Reset (reset=0 at falling edge): all stage valid bits 0, all data registers 0, ocupacao 0; reset overrides limpar and all transfers.
- Stage i = data register d[i] + valid bit v[i]; stage 0 is input side, stage ESTAGIOS-1 drives saida_registrada/saida_valida.
- Advance rule (combinational): avanca[ESTAGIOS-1] = !v[last] || saida_pronta; avanca[i] = !v[i] || avanca[i+1]. Bubbles collapse: a valid word moves into any empty downstream stage.
- entrada_pronta = avanca[0] && !limpar; input transfer when entrada_valida && entrada_pronta.
- Output transfer when saida_valida && saida_pronta.
- On an edge where stage i loads: d[i] <= d[i-1] (or entrada_dado for i=0), v[i] <= v[i-1] (or input transfer for i=0). Stages not advancing hold value.
- Data registers load only when the upstream source is valid; bubbles never overwrite data.
- Latency: word accepted at edge N appears with saida_valida=1 after edge N+ESTAGIOS-1 when unstalled; throughput 1 word/edge with saida_pronta held 1.
- Full: all v=1 and saida_pronta=0 -> entrada_pronta=0, nothing moves. Full with saida_pronta=1 -> simultaneous input and output accepted, ocupacao unchanged.
- Empty: saida_valida=0; saida_registrada holds its last value (do not check when invalid).
- limpar=1 at edge: all v <= 0, ocupacao <= 0, no input accepted; an output transfer signalled on that edge still counts as consumed. Data registers hold.
- ocupacao: registered counter, +1 on input transfer, -1 on output transfer, unchanged when both or neither; must always equal popcount(v). Range 0..ESTAGIOS, never wraps.
- ESTAGIOS=1 degenerates to a single register with valid/ready; combinational saida_pronta->entrada_pronta path allowed.

Optional Feature:
REGISTRADOR_PIPELINE_PARIDADE_EN: when defined, each stage stores an extra even-parity bit computed from entrada_dado at input transfer, and port erro_paridade (output, 1) = saida_valida && (^saida_registrada != stored parity); reset and limpar clear parity bits. When undefined, no parity storage, no erro_paridade port; behaviour otherwise identical.

Test Plan:
Reset: hold reset=0 two edges with entrada_valida=1 -> saida_valida=0, ocupacao=0, saida_registrada=8'h00.
Streaming: LARGURA=8, ESTAGIOS=4, saida_pronta=1, inputs 8'h11,8'h22,8'h33 on consecutive edges -> 8'h11 valid after 3rd edge following acceptance, then 8'h22, 8'h33 on successive edges, ocupacao peaks at 3.
Fill/stall: saida_pronta=0, push 8'hA0..8'hA4 -> first four accepted, entrada_pronta=0 at 5th, ocupacao=4; raise saida_pronta -> A0,A1,A2,A3 out in order, A4 accepted on first freed edge.
Bubble collapse: push 8'h5A, idle 2 edges, push 8'hC3 with saida_pronta=0 -> both reach stages 3 and 2 with no gap, ocupacao=2.
Flush: ocupacao=3, assert limpar with entrada_valida=1 data 8'hFF -> next ocupacao=0, saida_valida=0, 8'hFF never emerges.
Parity (macro on): corrupt stored bit of word 8'h0F via force -> erro_paridade=1 only while that word is at output with saida_valida=1.
